// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory and decode-stage handshake signals of the fetch stage.
interface instr_fetch_if #(parameter int IM_AW = 10);
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_dout;
  logic             if_valid;
  logic [31:0]      if_instr;
  logic [31:0]      if_pc;
  logic [31:0]      if_pc4;
  logic             id_ready;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             fault;
  modport master (
    output im_addr, if_valid, if_instr, if_pc, if_pc4, fault,
    input  im_dout, id_ready, redirect, redirect_pc
  );
  modport slave (
    input  im_addr, if_valid, if_instr, if_pc, if_pc4, fault,
    output im_dout, id_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches from combinational instruction memory, and handles stalls, redirects and faults.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_AW    = 10
) (
  input logic            clk,
  input logic            rst_n,
  instr_fetch_if.master  f
);
  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
  state_t      state;
  logic [31:0] pc, instr, ipc;
  logic        valid, flt, in_win;
  // Window is the 2^(IM_AW+2)-byte region that holds RESET_PC; stored redirect targets are checked here at fetch time.
  assign in_win     = (pc[31:IM_AW+2] == RESET_PC[31:IM_AW+2]) && (pc[1:0] == 2'b00);
  assign f.im_addr  = pc[IM_AW+1:2];
  assign f.if_valid = valid;
  assign f.if_instr = instr;
  assign f.if_pc    = ipc;
  assign f.if_pc4   = ipc + 32'd4;
  assign f.fault    = flt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= BOOT;
      pc    <= RESET_PC;
      valid <= 1'b0;
      instr <= '0;
      ipc   <= '0;
      flt   <= 1'b0;
    end else
      case (state)
        BOOT: state <= RUN;
        RUN:
          if (f.redirect) begin
            pc    <= f.redirect_pc;
            valid <= 1'b0;
          end else if (!valid || f.id_ready) begin
            if (in_win) begin
              instr <= f.im_dout;
              ipc   <= pc;
              valid <= 1'b1;
              pc    <= pc + 32'd4;
            end else begin
              state <= FAULT;
              flt   <= 1'b1;
              valid <= 1'b0;
            end
          end
        default: valid <= 1'b0;
      endcase
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for the fetch stage with a combinational instruction memory model.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [31:0] mem [1024];
  logic [31:0] exp_q [$];
  logic [31:0] e;

  instr_fetch_if #(.IM_AW(10)) b ();
  instr_fetch_unit #(.RESET_PC(32'h0000_3000), .IM_AW(10)) dut (.clk(clk), .rst_n(rst_n), .f(b));

  always #5 clk = ~clk;
  assign b.im_dout = mem[b.im_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b.id_ready = 1'b0;
    b.redirect = 1'b0;
    b.redirect_pc = '0;
    #3;
    tests++;
    if (b.if_valid !== 1'b0 || b.if_pc !== 32'h0 || b.if_instr !== 32'h0 || b.if_pc4 !== 32'h4 || b.fault !== 1'b0 || b.im_addr !== 10'd0) begin
      fails++;
      $display("FAIL reset_values: valid=%b pc=%h instr=%h pc4=%h fault=%b im_addr=%0d required 0/0/0/4/0/0",
               b.if_valid, b.if_pc, b.if_instr, b.if_pc4, b.fault, b.im_addr);
    end
    step();
    rst_n = 1'b1;
    b.id_ready = 1'b1;
    exp_q.push_back(32'h3000);
    exp_q.push_back(32'h3004);
    exp_q.push_back(32'h3008);
    step();
    tests++;
    if (b.if_valid !== 1'b0) begin
      fails++;
      $display("FAIL boot_no_capture: valid=%b required 0", b.if_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      e = exp_q.pop_front();
      tests++;
      if (b.if_valid !== 1'b1 || b.if_pc !== e || b.if_instr !== mem[e[11:2]] || b.if_pc4 !== e + 32'd4) begin
        fails++;
        $display("FAIL boot_fetch: valid=%b pc=%h instr=%h pc4=%h required 1 pc=%h instr=%h pc4=%h",
                 b.if_valid, b.if_pc, b.if_instr, b.if_pc4, e, mem[e[11:2]], e + 32'd4);
      end
    end
  endtask

  task automatic test_stall();
    b.redirect = 1'b1;
    b.redirect_pc = 32'h3004;
    exp_q.push_back(32'h3004);
    step();
    b.redirect = 1'b0;
    step();
    e = exp_q.pop_front();
    tests++;
    if (b.if_valid !== 1'b1 || b.if_pc !== e || b.if_instr !== mem[e[11:2]]) begin
      fails++;
      $display("FAIL stall_entry: valid=%b pc=%h instr=%h required 1 pc=%h instr=%h", b.if_valid, b.if_pc, b.if_instr, e, mem[e[11:2]]);
    end
    b.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (b.if_valid !== 1'b1 || b.if_pc !== 32'h3004 || b.if_instr !== 32'h00221821 || b.im_addr !== 10'd2) begin
        fails++;
        $display("FAIL stall_hold: valid=%b pc=%h instr=%h im_addr=%0d required 1 pc=00003004 instr=00221821 im_addr=2",
                 b.if_valid, b.if_pc, b.if_instr, b.im_addr);
      end
    end
    b.id_ready = 1'b1;
    exp_q.push_back(32'h3008);
    step();
    e = exp_q.pop_front();
    tests++;
    if (b.if_valid !== 1'b1 || b.if_pc !== e || b.if_instr !== mem[e[11:2]]) begin
      fails++;
      $display("FAIL stall_release: valid=%b pc=%h instr=%h required 1 pc=%h instr=%h", b.if_valid, b.if_pc, b.if_instr, e, mem[e[11:2]]);
    end
  endtask

  task automatic test_redirect();
    b.redirect = 1'b1;
    b.redirect_pc = 32'h3028;
    step();
    b.redirect = 1'b0;
    step();
    tests++;
    if (b.if_valid !== 1'b1 || b.if_pc !== 32'h3028) begin
      fails++;
      $display("FAIL redirect_setup: valid=%b pc=%h required 1 pc=00003028", b.if_valid, b.if_pc);
    end
    b.id_ready = 1'b0;
    b.redirect = 1'b1;
    b.redirect_pc = 32'h3024;
    exp_q.push_back(32'h3024);
    exp_q.push_back(32'h3028);
    exp_q.push_back(32'h302C);
    step();
    tests++;
    if (b.if_valid !== 1'b0) begin
      fails++;
      $display("FAIL redirect_flush: valid=%b required 0", b.if_valid);
    end
    b.redirect = 1'b0;
    b.id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      e = exp_q.pop_front();
      tests++;
      if (b.if_valid !== 1'b1 || b.if_pc !== e || b.if_instr !== mem[e[11:2]] || b.if_pc4 !== e + 32'd4) begin
        fails++;
        $display("FAIL redirect_fetch: valid=%b pc=%h instr=%h pc4=%h required 1 pc=%h instr=%h pc4=%h",
                 b.if_valid, b.if_pc, b.if_instr, b.if_pc4, e, mem[e[11:2]], e + 32'd4);
      end
    end
  endtask

  task automatic test_jal();
    b.redirect = 1'b1;
    b.redirect_pc = 32'h3000;
    tests++;
    if (b.if_pc4 !== 32'h3030) begin
      fails++;
      $display("FAIL jal_link: pc4=%h required 00003030", b.if_pc4);
    end
    exp_q.push_back(32'h3000);
    exp_q.push_back(32'h3004);
    step();
    tests++;
    if (b.if_valid !== 1'b0) begin
      fails++;
      $display("FAIL jal_bubble: valid=%b required 0", b.if_valid);
    end
    b.redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      e = exp_q.pop_front();
      tests++;
      if (b.if_valid !== 1'b1 || b.if_pc !== e || b.if_instr !== mem[e[11:2]]) begin
        fails++;
        $display("FAIL jal_restart: valid=%b pc=%h instr=%h required 1 pc=%h instr=%h", b.if_valid, b.if_pc, b.if_instr, e, mem[e[11:2]]);
      end
    end
  endtask

  task automatic test_back_to_back();
    b.redirect = 1'b1;
    b.redirect_pc = 32'h3100;
    step();
    b.redirect_pc = 32'h3200;
    exp_q.push_back(32'h3200);
    step();
    tests++;
    if (b.if_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_bubble: valid=%b required 0", b.if_valid);
    end
    b.redirect = 1'b0;
    step();
    e = exp_q.pop_front();
    tests++;
    if (b.if_valid !== 1'b1 || b.if_pc !== e || b.if_instr !== mem[e[11:2]]) begin
      fails++;
      $display("FAIL b2b_later_wins: valid=%b pc=%h instr=%h required 1 pc=%h instr=%h", b.if_valid, b.if_pc, b.if_instr, e, mem[e[11:2]]);
    end
  endtask

  task automatic test_fault(input logic [31:0] bad);
    b.redirect = 1'b1;
    b.redirect_pc = bad;
    step();
    b.redirect = 1'b0;
    tests++;
    if (b.if_valid !== 1'b0 || b.fault !== 1'b0) begin
      fails++;
      $display("FAIL fault_deferred %h: valid=%b fault=%b required 0/0", bad, b.if_valid, b.fault);
    end
    step();
    tests++;
    if (b.fault !== 1'b1 || b.if_valid !== 1'b0) begin
      fails++;
      $display("FAIL fault_raise %h: fault=%b valid=%b required 1/0", bad, b.fault, b.if_valid);
    end
    b.redirect = 1'b1;
    b.redirect_pc = 32'h3010;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (b.fault !== 1'b1 || b.if_valid !== 1'b0 || b.im_addr !== bad[11:2]) begin
        fails++;
        $display("FAIL fault_sticky %h: fault=%b valid=%b im_addr=%0d required 1/0/%0d", bad, b.fault, b.if_valid, b.im_addr, bad[11:2]);
      end
    end
    b.redirect = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (b.fault !== 1'b0 || b.if_valid !== 1'b0 || b.im_addr !== 10'd0) begin
      fails++;
      $display("FAIL fault_async_clear: fault=%b valid=%b im_addr=%0d required 0/0/0", b.fault, b.if_valid, b.im_addr);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    tests++;
    if (b.if_valid !== 1'b1 || b.if_pc !== 32'h3000) begin
      fails++;
      $display("FAIL fault_reboot: valid=%b pc=%h required 1 pc=00003000", b.if_valid, b.if_pc);
    end
  endtask

  task automatic test_async_reset();
    step();
    tests++;
    if (b.if_valid !== 1'b1 || b.im_addr !== 10'd2) begin
      fails++;
      $display("FAIL async_pre: valid=%b im_addr=%0d required 1/2", b.if_valid, b.im_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (b.if_valid !== 1'b0 || b.fault !== 1'b0 || b.im_addr !== 10'd0 || b.if_pc !== 32'h0 || b.if_pc4 !== 32'h4) begin
      fails++;
      $display("FAIL async_reset: valid=%b fault=%b im_addr=%0d pc=%h pc4=%h required 0/0/0/0/4",
               b.if_valid, b.fault, b.im_addr, b.if_pc, b.if_pc4);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'h00221823;
    mem[1] = 32'h00221821;
    mem[2] = 32'h34410005;
    test_reset();
    test_stall();
    test_redirect();
    test_jal();
    test_back_to_back();
    test_fault(32'h3002);
    test_fault(32'h4000);
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that drives the 10-bit word address into the instruction memory and captures the returned 32-bit instruction. It presents the instruction to the decode stage over a valid/ready handshake. It owns the program counter and handles sequential PC+4 advance, stalls from decode, and redirects (taken beq, j, jal, jr) with a single-cycle flush. It faults on misaligned or out-of-window addresses.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset; word 0 of instruction memory.
- IM_AW, 10, instruction memory word-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- im_addr  out  IM_AW  word address to instruction memory; equals pc[IM_AW+1:2], combinational from pc register.
- im_dout  in  32  instruction returned combinationally by instruction memory for im_addr.
- if_valid  out  1  if_instr/if_pc/if_pc4 hold a valid fetched instruction.
- if_instr  out  32  fetched instruction.
- if_pc  out  32  byte address of if_instr.
- if_pc4  out  32  if_pc + 4; the link value for jal.
- id_ready  in  1  decode accepts the current instruction this cycle.
- redirect  in  1  decode requests a PC change (taken branch or jump).
- redirect_pc  in  32  target byte address, sampled when redirect=1.
- fault  out  1  sticky fetch fault; cleared only by reset.

## Operation
- State machine: BOOT, RUN, FAULT.
- Reset, asynchronous: pc=RESET_PC, state=BOOT, if_valid=0, if_instr=0, if_pc=0, fault=0. if_pc4 is a function of if_pc, so it reads 4 during reset.
- BOOT: exactly one cycle after rst_n deasserts. No capture. Next state is RUN.
- Window check:
  - pc is in window iff pc[31:IM_AW+2]==RESET_PC[31:IM_AW+2] and pc[1:0]==0.
  - Stored redirect_pc is checked on the cycle it would be fetched, not when it is stored.
- Fetch, when RUN, redirect=0, and (if_valid==0 or id_ready==1):
  - pc in window: if_instr<=im_dout, if_pc<=pc, if_valid<=1, pc<=pc+4 (mod 2^32).
  - pc out of window: state<=FAULT, fault<=1, if_valid<=0, pc held.
- Stall, when RUN, redirect=0, if_valid==1, id_ready==0: pc, if_instr, if_pc, and if_valid all hold.
- Redirect, when RUN and redirect=1:
  - Redirect has priority over fetch and stall, regardless of id_ready.
  - Action: pc<=redirect_pc, if_valid<=0, which flushes the held instruction.
- FAULT: terminal until reset. if_valid=0, pc frozen, redirect and id_ready ignored.
- Redirect during BOOT: ignored.
- Instruction memory is a combinational read, so im_dout corresponds to the current pc in the same cycle. No request/response signalling is needed.

## Timing
- Reset to first if_valid=1: pc=RESET_PC is captured at the 2nd rising edge after rst_n deasserts (edge 1 leaves BOOT, edge 2 captures).
- Throughput: one instruction per cycle while id_ready=1.
- Handshake: an instruction is consumed on an edge where if_valid=1 and id_ready=1. The next instruction appears at that same edge.
- Redirect latency:
  - Edge N samples redirect=1 and clears if_valid.
  - Edge N+1 captures the target with if_valid=1.
  - Cost is exactly one bubble cycle.
- Redirect and id_ready=1 in the same cycle: the current instruction counts as consumed, and the flush still occurs.
- Back-to-back redirects: the later one wins. if_valid stays 0 until a cycle with redirect=0.
- rst_n asserted mid-stream, including mid-stall or in FAULT: all outputs return to reset values immediately, without waiting for a clock edge.
- PC wrap from 32'hFFFF_FFFC to 0: permitted arithmetically, but the resulting pc is out of window and raises FAULT.

## Test plan
- Reset/boot: memory words 0..2 = 32'h00221823, 32'h00221821, 32'h34410005; release rst_n; id_ready=1 → edge 2 gives if_pc=0x3000, if_instr=0x00221823, if_pc4=0x3004; edges 3 and 4 give 0x3004 and 0x3008 with the matching words.
- Stall: id_ready=0 for 3 cycles while if_pc=0x3004 → if_instr=0x00221821 held, im_addr=2 held; on release, next capture is 0x3008.
- Redirect: redirect=1, redirect_pc=0x3024 while if_pc=0x3028 and id_ready=0 → next cycle if_valid=0; following edge gives if_pc=0x3024 and the instruction at word 9.
- jal loop: redirect_pc=0x3000 at if_pc=0x302C → if_pc4 before the flush reads 0x3030; fetch restarts at word 0 after one bubble.
- Faults:
  - redirect_pc=0x3002 → fault=1 one edge after the fetch attempt; if_valid stays 0; further redirects are ignored.
  - redirect_pc=0x4000 → same behaviour as 0x3002.
- Asynchronous reset mid-run: assert rst_n=0 between edges while if_valid=1 → if_valid=0, fault=0, im_addr=0 immediately.
